// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2-read / 2-write register file with reset-cleared
// storage, optional write-to-read bypass, optional hardwired zero register
// and a per-register pending-load scoreboard for RAW hazard stalls.
module regfile_scoreboard #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned ZERO_REG = 0,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_a_addr,
  output logic [DATA_W-1:0] rd_a_data,
  output logic              rd_a_busy,
  input  logic [ADDR_W-1:0] rd_b_addr,
  output logic [DATA_W-1:0] rd_b_data,
  output logic              rd_b_busy,
  input  logic              wr_a_en,
  input  logic [ADDR_W-1:0] wr_a_addr,
  input  logic [DATA_W-1:0] wr_a_data,
  input  logic              wr_b_en,
  input  logic [ADDR_W-1:0] wr_b_addr,
  input  logic [DATA_W-1:0] wr_b_data,
  input  logic              pend_set,
  input  logic [ADDR_W-1:0] pend_addr,
  output logic [ADDR_W:0]   pend_cnt,
  output logic              pend_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pend_nxt;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              err_q;
  logic              err_nxt;

  logic              wa_commit;
  logic              wb_commit;
  logic              pset_eff;

  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_dat  [2];
  logic              rd_bsy  [2];

  // True when the address is the hardwired zero register.
  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Effective write/set qualifiers: zero register masking, port A wins on
  // an address collision so port B is dropped.
  always_comb begin
    wa_commit = wr_a_en && !is_zero(wr_a_addr);
    wb_commit = wr_b_en && !is_zero(wr_b_addr) &&
                !(wa_commit && (wr_a_addr == wr_b_addr));
    pset_eff  = pend_set && !is_zero(pend_addr);
  end

  // Register storage: cleared on reset, both ports commit at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[ADDR_W'(i)] <= '0;
      end
    end else begin
      if (wa_commit) mem[wr_a_addr] <= wr_a_data;
      if (wb_commit) mem[wr_b_addr] <= wr_b_data;
    end
  end

  // Next scoreboard state: writes retire loads, then a new load is marked,
  // so a set and a write to the same register leave the bit set.
  always_comb begin
    pend_nxt = pend;
    if (wa_commit) pend_nxt[wr_a_addr] = 1'b0;
    if (wb_commit) pend_nxt[wr_b_addr] = 1'b0;
    if (pset_eff)  pend_nxt[pend_addr] = 1'b1;
    // A set is only an error if the old load is still outstanding
    // after this edge's writes.
    err_nxt = pset_eff && pend[pend_addr] &&
              !(wa_commit && (wr_a_addr == pend_addr)) &&
              !(wb_commit && (wr_b_addr == pend_addr));
    cnt_nxt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      cnt_nxt = cnt_nxt + CNT_W'(pend_nxt[ADDR_W'(i)]);
    end
  end

  // Scoreboard bits, registered popcount and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      pend  <= pend_nxt;
      cnt_q <= cnt_nxt;
      err_q <= err_nxt;
    end
  end

  assign pend_cnt = cnt_q;
  assign pend_err = err_q;

  assign rd_addr[0] = rd_a_addr;
  assign rd_addr[1] = rd_b_addr;

  // Combinational read ports with optional bypass; outputs are forced to
  // zero while reset is asserted so in-flight write data cannot leak out.
  always_comb begin
    logic hit_a;
    logic hit_b;
    logic hit_p;
    for (int unsigned p = 0; p < 2; p++) begin
      hit_a = wa_commit && (wr_a_addr == rd_addr[1'(p)]);
      hit_b = wb_commit && (wr_b_addr == rd_addr[1'(p)]);
      hit_p = pset_eff  && (pend_addr == rd_addr[1'(p)]);
      rd_dat[1'(p)] = mem[rd_addr[1'(p)]];
      rd_bsy[1'(p)] = pend[rd_addr[1'(p)]];
      if (BYPASS != 0) begin
        if (hit_a)      rd_dat[1'(p)] = wr_a_data;
        else if (hit_b) rd_dat[1'(p)] = wr_b_data;
        if ((hit_a || hit_b) && !hit_p) rd_bsy[1'(p)] = 1'b0;
      end
      if (is_zero(rd_addr[1'(p)]) || !rst_n) begin
        rd_dat[1'(p)] = '0;
        rd_bsy[1'(p)] = 1'b0;
      end
    end
  end

  assign rd_a_data = rd_dat[0];
  assign rd_b_data = rd_dat[1];
  assign rd_a_busy = rd_bsy[0];
  assign rd_b_busy = rd_bsy[1];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed table-driven bench for regfile_scoreboard (ZERO_REG=1, BYPASS=1).
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst_n;
  logic [3:0]  rd_a_addr, rd_b_addr;
  logic [15:0] rd_a_data, rd_b_data;
  logic        rd_a_busy, rd_b_busy;
  logic        wr_a_en, wr_b_en;
  logic [3:0]  wr_a_addr, wr_b_addr;
  logic [15:0] wr_a_data, wr_b_data;
  logic        pend_set;
  logic [3:0]  pend_addr;
  logic [4:0]  pend_cnt;
  logic        pend_err;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard #(
    .DATA_W(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_a_addr(rd_a_addr), .rd_a_data(rd_a_data), .rd_a_busy(rd_a_busy),
    .rd_b_addr(rd_b_addr), .rd_b_data(rd_b_data), .rd_b_busy(rd_b_busy),
    .wr_a_en(wr_a_en), .wr_a_addr(wr_a_addr), .wr_a_data(wr_a_data),
    .wr_b_en(wr_b_en), .wr_b_addr(wr_b_addr), .wr_b_data(wr_b_data),
    .pend_set(pend_set), .pend_addr(pend_addr),
    .pend_cnt(pend_cnt), .pend_err(pend_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wa_en; logic [3:0] wa_addr; logic [15:0] wa_data;
    logic        wb_en; logic [3:0] wb_addr; logic [15:0] wb_data;
    logic        ps;    logic [3:0] pa;
    logic [3:0]  ra;    logic [3:0] rb;
    logic [15:0] exp_ad; logic [15:0] exp_bd;
    logic        exp_ab; logic exp_bb;
    logic [4:0]  exp_cnt; logic exp_err;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(
    input logic wa_en, input logic [3:0] wa_addr, input logic [15:0] wa_data,
    input logic wb_en, input logic [3:0] wb_addr, input logic [15:0] wb_data,
    input logic ps, input logic [3:0] pa, input logic [3:0] ra, input logic [3:0] rb,
    input logic [15:0] ead, input logic [15:0] ebd, input logic eab, input logic ebb,
    input logic [4:0] ecnt, input logic eerr);
    vec_t v;
    v.wa_en = wa_en; v.wa_addr = wa_addr; v.wa_data = wa_data;
    v.wb_en = wb_en; v.wb_addr = wb_addr; v.wb_data = wb_data;
    v.ps = ps; v.pa = pa; v.ra = ra; v.rb = rb;
    v.exp_ad = ead; v.exp_bd = ebd; v.exp_ab = eab; v.exp_bb = ebb;
    v.exp_cnt = ecnt; v.exp_err = eerr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    wr_a_en = 1'b0; wr_a_addr = '0; wr_a_data = '0;
    wr_b_en = 1'b0; wr_b_addr = '0; wr_b_data = '0;
    pend_set = 1'b0; pend_addr = '0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    // Each row: inputs for one cycle, combinational expectations for that
    // cycle, and registered pend_cnt/pend_err as left by earlier edges.
    //              wa en,addr,data     wb en,addr,data     ps,pa  ra, rb  rd_a     rd_b     ba bb cnt err
    vecs[0]  = mk(1, 3, 16'h1234, 1, 5, 16'hBEEF, 0, 0,  3, 5,  16'h1234, 16'hBEEF, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,  3, 5,  16'h1234, 16'hBEEF, 0, 0, 0, 0);
    vecs[2]  = mk(1, 7, 16'hAAAA, 1, 7, 16'h5555, 0, 0,  7, 7,  16'hAAAA, 16'hAAAA, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,  7, 7,  16'hAAAA, 16'hAAAA, 0, 0, 0, 0);
    vecs[4]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 9,  9, 9,  16'h0000, 16'h0000, 0, 0, 0, 0);
    vecs[5]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,  9, 9,  16'h0000, 16'h0000, 1, 1, 1, 0);
    vecs[6]  = mk(0, 0, 16'h0000, 1, 9, 16'h00FF, 0, 0,  9, 3,  16'h00FF, 16'h1234, 0, 0, 1, 0);
    vecs[7]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,  9, 9,  16'h00FF, 16'h00FF, 0, 0, 0, 0);
    vecs[8]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 2,  2, 2,  16'h0000, 16'h0000, 0, 0, 0, 0);
    vecs[9]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 2,  2, 2,  16'h0000, 16'h0000, 1, 1, 1, 0);
    vecs[10] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,  2, 2,  16'h0000, 16'h0000, 1, 1, 1, 1);
    vecs[11] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,  2, 2,  16'h0000, 16'h0000, 1, 1, 1, 0);
    vecs[12] = mk(1, 0, 16'hFFFF, 0, 0, 16'h0000, 1, 0,  0, 2,  16'h0000, 16'h0000, 0, 1, 1, 0);
    vecs[13] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0,  0, 2,  16'h0000, 16'h0000, 0, 1, 1, 0);
    vecs[14] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,  0, 2,  16'h0000, 16'h0000, 0, 1, 1, 0);
    vecs[15] = mk(1, 11, 16'h2222, 0, 0, 16'h0000, 1, 11, 11, 11, 16'h2222, 16'h2222, 0, 0, 1, 0);
    vecs[16] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 11, 2,  16'h2222, 16'h0000, 1, 1, 2, 0);
    vecs[17] = mk(1, 2, 16'h0202, 1, 11, 16'h1111, 0, 0, 2, 11, 16'h0202, 16'h1111, 0, 0, 2, 0);
    vecs[18] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,  2, 11, 16'h0202, 16'h1111, 0, 0, 0, 0);

    idle_inputs();
    rd_a_addr = '0; rd_b_addr = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #2;

    // Reset state across the whole address space.
    for (int i = 0; i < 16; i++) begin
      rd_a_addr = 4'(i);
      rd_b_addr = 4'(15 - i);
      #1;
      chk($sformatf("reset rd_a_data[%0d]", i), 32'(rd_a_data), 32'h0);
      chk($sformatf("reset rd_b_data[%0d]", 15 - i), 32'(rd_b_data), 32'h0);
      chk($sformatf("reset busy[%0d]", i), {30'b0, rd_a_busy, rd_b_busy}, 32'h0);
    end
    chk("reset pend_cnt", 32'(pend_cnt), 32'h0);
    chk("reset pend_err", 32'(pend_err), 32'h0);

    // Table-driven vectors.
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      wr_a_en = vecs[i].wa_en; wr_a_addr = vecs[i].wa_addr; wr_a_data = vecs[i].wa_data;
      wr_b_en = vecs[i].wb_en; wr_b_addr = vecs[i].wb_addr; wr_b_data = vecs[i].wb_data;
      pend_set = vecs[i].ps; pend_addr = vecs[i].pa;
      rd_a_addr = vecs[i].ra; rd_b_addr = vecs[i].rb;
      #2;
      chk($sformatf("v%0d rd_a_data", i), 32'(rd_a_data), 32'(vecs[i].exp_ad));
      chk($sformatf("v%0d rd_b_data", i), 32'(rd_b_data), 32'(vecs[i].exp_bd));
      chk($sformatf("v%0d rd_a_busy", i), 32'(rd_a_busy), 32'(vecs[i].exp_ab));
      chk($sformatf("v%0d rd_b_busy", i), 32'(rd_b_busy), 32'(vecs[i].exp_bb));
      chk($sformatf("v%0d pend_cnt", i), 32'(pend_cnt), 32'(vecs[i].exp_cnt));
      chk($sformatf("v%0d pend_err", i), 32'(pend_err), 32'(vecs[i].exp_err));
    end

    // Asynchronous reset in the middle of a cycle with activity pending.
    @(negedge clk); idle_inputs(); pend_set = 1'b1; pend_addr = 4'd1;
    @(negedge clk); pend_addr = 4'd4;
    @(negedge clk); pend_addr = 4'd6;
    @(negedge clk); idle_inputs(); wr_a_en = 1'b1; wr_a_addr = 4'd4; wr_a_data = 16'h0F0F;
    @(negedge clk); idle_inputs(); rd_a_addr = 4'd4; rd_b_addr = 4'd1;
    #2;
    chk("pre-reset pend_cnt", 32'(pend_cnt), 32'd2);
    chk("pre-reset rd_a_data", 32'(rd_a_data), 32'h0F0F);
    chk("pre-reset rd_b_busy", 32'(rd_b_busy), 32'h1);
    @(posedge clk); #2;
    wr_a_en = 1'b1; wr_a_addr = 4'd4; wr_a_data = 16'hDEAD;
    pend_set = 1'b1; pend_addr = 4'd3;
    rst_n = 1'b0;
    #1;
    chk("in-reset rd_a_data", 32'(rd_a_data), 32'h0);
    chk("in-reset rd_b_busy", 32'(rd_b_busy), 32'h0);
    chk("in-reset pend_cnt", 32'(pend_cnt), 32'h0);
    chk("in-reset pend_err", 32'(pend_err), 32'h0);
    rd_b_addr = 4'd6;
    #1;
    chk("in-reset rd_b_busy6", 32'(rd_b_busy), 32'h0);
    @(posedge clk);
    @(negedge clk); idle_inputs(); rst_n = 1'b1;
    rd_a_addr = 4'd4; rd_b_addr = 4'd3;
    #2;
    chk("post-reset rd_a_data", 32'(rd_a_data), 32'h0);
    chk("post-reset rd_b_data", 32'(rd_b_data), 32'h0);
    chk("post-reset busy", {30'b0, rd_a_busy, rd_b_busy}, 32'h0);
    chk("post-reset pend_cnt", 32'(pend_cnt), 32'h0);
    @(negedge clk); #2;
    chk("post-reset idle pend_cnt", 32'(pend_cnt), 32'h0);
    chk("post-reset idle pend_err", 32'(pend_err), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised successor to the CPU's 2-read/2-write register file. It adds:
- reset-cleared storage
- true dual-port write
- optional write-to-read bypass
- optional hardwired zero register
- a per-register pending-load scoreboard, so the control unit can stall on RAW hazards against outstanding memory loads

It sits between the decode/control unit (R_Bus/S_Bus reads) and the D_Bus/D_Addr writeback paths.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers
ZERO_REG, 0, 1 = register 0 always reads 0; writes and pend_set to it are ignored
BYPASS, 1, 1 = same-cycle write data is forwarded to the read ports

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
rd_a_addr  in  ADDR_W  read port A address (R_Bus)
rd_a_data  out  DATA_W  read port A data
rd_a_busy  out  1  register at rd_a_addr has a pending load
rd_b_addr  in  ADDR_W  read port B address (S_Bus)
rd_b_data  out  DATA_W  read port B data
rd_b_busy  out  1  register at rd_b_addr has a pending load
wr_a_en  in  1  write port A enable (D_Bus, priority port)
wr_a_addr  in  ADDR_W  write port A address
wr_a_data  in  DATA_W  write port A data
wr_b_en  in  1  write port B enable (D_Addr writeback)
wr_b_addr  in  ADDR_W  write port B address
wr_b_data  in  DATA_W  write port B data
pend_set  in  1  mark pend_addr as awaiting a load
pend_addr  in  ADDR_W  register to mark pending
pend_cnt  out  ADDR_W+1  number of registers currently pending
pend_err  out  1  registered pulse: pend_set hit an already-pending register

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers and pending bits clear to 0
  - pend_cnt = 0, pend_err = 0
  - read data outputs = 0, busy outputs = 0
  - A write in flight during reset is discarded.
- Reads are combinational and have zero latency. The stored value is visible the cycle after the write edge.
- Writes, at the rising edge:
  - wr_a and wr_b to different addresses: both commit in the same cycle.
  - Same address: wr_a data is stored and wr_b is dropped.
- BYPASS=1: when a read address matches an enabled write address in the same cycle, read data = write data (wr_a takes priority over wr_b). BYPASS=0: read returns the stored value only.
- ZERO_REG=1: address 0 reads 0 and is never busy. Writes and pend_set to address 0 have no effect and never raise pend_err.
- Scoreboard (pending bit per register):
  - Set: pend_set at the edge sets pend[pend_addr].
  - Clear: any committed write (port A or B) to an address clears its bit at the same edge.
  - pend_set and a write to the same address in the same cycle: the bit ends set (the new load is issued after the old value retires). The write data is still stored.
  - pend_set to an already-set bit: the bit stays set and pend_err = 1 for exactly the next cycle. pend_cnt is not incremented.
- rd_x_busy = pend[rd_x_addr], except 0 when BYPASS=1 and a same-cycle write hits that address with no same-cycle pend_set to it.
- pend_cnt:
  - registered
  - equals the popcount of the pending bits after each edge
  - range 0..DEPTH
  - no wrap

Test Plan:
- Reset then read all 16 addresses -> every rd_a_data/rd_b_data = 0x0000, busy = 0, pend_cnt = 0.
- wr_a (addr 3, 0x1234) and wr_b (addr 5, 0xBEEF) in the same cycle -> next cycle rd_a addr 3 = 0x1234, rd_b addr 5 = 0xBEEF.
- wr_a (addr 7, 0xAAAA) and wr_b (addr 7, 0x5555) in the same cycle -> reg 7 = 0xAAAA; with BYPASS=1 a same-cycle read of addr 7 also returns 0xAAAA.
- pend_set addr 9 -> rd_a_busy = 1 and pend_cnt = 1 next cycle. Then wr_b (addr 9, 0x00FF) -> same-cycle busy = 0 (BYPASS), next cycle pend_cnt = 0, read = 0x00FF.
- pend_set addr 2 on two consecutive cycles -> pend_err = 1 for one cycle only, pend_cnt stays 1. ZERO_REG=1: pend_set addr 0 -> no change, pend_err = 0.
- Set pending on addrs 1, 4, 6, write 0x0F0F to addr 4, then pulse rst_n low mid-cycle -> all outputs go to 0 immediately, without waiting for a clock edge.
